// File: rtl/fx3_bus_pkg.sv
// Shared types and helpers for the FX3 slave-FIFO bus paths.
// Holds the in-path state encoding and the socket-width helper.
package fx3_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_READ     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_FINISHED = 3'd4
    } state_t;

    localparam int DEFAULT_RD_LATENCY = 2;

    // A single socket still needs one address bit on the FX3 side.
    function automatic int ch_width_for(input int num_ch);
        if (num_ch <= 2) begin
            return 1;
        end
        return $clog2(num_ch);
    endfunction

endpackage

// File: rtl/fx3_rd_latency_pipe.sv
// Shift register tracking issued reads through the FX3 read latency.
// Exposes the last two stages and an all-clear flag.
module fx3_rd_latency_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_in,
    output logic pre_tap,
    output logic out_tap,
    output logic empty
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], shift_in};
        end
    end

    // pre_tap marks the cycle whose pad data must be captured; out_tap
    // lines up with that captured word being presented.
    assign pre_tap = stages[DEPTH-2];
    assign out_tap = stages[DEPTH-1];
    assign empty   = (stages == '0);

endmodule

// File: rtl/fx3_bus_in_path_mc.sv
// Multi-socket FX3 slave-FIFO read path: latches socket and length, drives
// SLOE/SLRD, and realigns read data with a latency-compensating valid pipe.
module fx3_bus_in_path_mc
    import fx3_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 24,
    parameter int RD_LATENCY = DEFAULT_RD_LATENCY,
    parameter int NUM_CH     = 4,
    parameter int CH_WIDTH   = ch_width_for(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_in_path_enable,
    input  logic [CH_WIDTH-1:0]   i_channel,
    input  logic [SIZE_WIDTH-1:0] i_packet_size,
    input  logic                  i_read_flow_cntrl,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_fx3_data,
    output logic [CH_WIDTH-1:0]   o_fx3_addr,
    output logic                  o_output_enable,
    output logic                  o_read_enable,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic [SIZE_WIDTH-1:0] o_word_count,
    output logic                  o_in_path_busy,
    output logic                  o_in_path_finished,
    output logic                  o_short_packet
);

    state_t                state;
    logic [SIZE_WIDTH-1:0] r_size;
    logic [SIZE_WIDTH-1:0] r_issued;
    logic                  last_issue;
    logic                  capture;
    logic                  pipe_empty;

    // SLRD is combinational so a flow drop or abort suppresses it in the same cycle.
    assign o_read_enable = (state == ST_READ) && i_read_flow_cntrl && !i_abort;
    assign last_issue    = (r_issued == r_size - SIZE_WIDTH'(1));

    fx3_rd_latency_pipe #(
        .DEPTH(RD_LATENCY + 1)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .shift_in(o_read_enable),
        .pre_tap (capture),
        .out_tap (o_data_valid),
        .empty   (pipe_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            o_fx3_addr         <= '0;
            r_size             <= '0;
            r_issued           <= '0;
            o_output_enable    <= 1'b0;
            o_in_path_busy     <= 1'b0;
            o_in_path_finished <= 1'b0;
            o_short_packet     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_in_path_enable) begin
                        o_fx3_addr <= i_channel;
                        r_size     <= i_packet_size;
                        r_issued   <= '0;
                        if (i_packet_size == '0) begin
                            state              <= ST_FINISHED;
                            o_in_path_finished <= 1'b1;
                            o_short_packet     <= 1'b0;
                        end else begin
                            state           <= ST_SETUP;
                            o_output_enable <= 1'b1;
                            o_in_path_busy  <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    state <= ST_READ;
                end
                ST_READ: begin
                    if (o_read_enable) begin
                        r_issued <= r_issued + SIZE_WIDTH'(1);
                    end
                    if (i_abort || (o_read_enable && last_issue)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // An empty pipe means every captured word has already been counted.
                    if (pipe_empty) begin
                        state              <= ST_FINISHED;
                        o_output_enable    <= 1'b0;
                        o_in_path_busy     <= 1'b0;
                        o_in_path_finished <= 1'b1;
                        o_short_packet     <= (o_word_count < r_size);
                    end
                end
                ST_FINISHED: begin
                    if (!i_in_path_enable) begin
                        state              <= ST_IDLE;
                        o_in_path_finished <= 1'b0;
                        o_short_packet     <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Count and data update on the capture edge, so the count already
    // includes the word being presented alongside o_data_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data       <= '0;
            o_word_count <= '0;
        end else begin
            if (capture) begin
                o_data <= i_fx3_data;
            end
            if (state == ST_IDLE && i_in_path_enable) begin
                o_word_count <= '0;
            end else if (capture) begin
                o_word_count <= o_word_count + SIZE_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fx3_bus_in_path_mc.sv
// Directed bench for fx3_bus_in_path_mc: cycle-by-cycle checks of SLRD/SLOE,
// valid timing, data order and completion status, plus a latency-5 instance.
module tb_fx3_bus_in_path_mc;

    localparam int DW  = 32;
    localparam int SW  = 24;
    localparam int CW  = 2;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_in_path_enable;
    logic          en5;
    logic [CW-1:0] i_channel;
    logic [SW-1:0] i_packet_size;
    logic          i_read_flow_cntrl;
    logic          i_abort;
    logic [DW-1:0] i_fx3_data;

    logic [CW-1:0] o_fx3_addr, addr5;
    logic          o_output_enable, oe5;
    logic          o_read_enable, re5;
    logic [DW-1:0] o_data, data5;
    logic          o_data_valid, valid5;
    logic [SW-1:0] o_word_count, wc5;
    logic          o_in_path_busy, busy5;
    logic          o_in_path_finished, fin5;
    logic          o_short_packet, short5;

    int            tests = 0;
    int            failures = 0;
    int            cyc = 0;
    int            exp_wc = 0;
    logic [15:0]   re_hist;
    logic [CW-1:0] exp_addr;

    always #5 clk = ~clk;

    fx3_bus_in_path_mc #(
        .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .RD_LATENCY(LAT), .NUM_CH(4), .CH_WIDTH(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .i_in_path_enable(i_in_path_enable), .i_channel(i_channel),
        .i_packet_size(i_packet_size), .i_read_flow_cntrl(i_read_flow_cntrl), .i_abort(i_abort),
        .i_fx3_data(i_fx3_data), .o_fx3_addr(o_fx3_addr), .o_output_enable(o_output_enable),
        .o_read_enable(o_read_enable), .o_data(o_data), .o_data_valid(o_data_valid),
        .o_word_count(o_word_count), .o_in_path_busy(o_in_path_busy),
        .o_in_path_finished(o_in_path_finished), .o_short_packet(o_short_packet)
    );

    fx3_bus_in_path_mc #(
        .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .RD_LATENCY(5), .NUM_CH(4), .CH_WIDTH(CW)
    ) u_dut5 (
        .clk(clk), .rst(rst), .i_in_path_enable(en5), .i_channel(i_channel),
        .i_packet_size(i_packet_size), .i_read_flow_cntrl(i_read_flow_cntrl), .i_abort(i_abort),
        .i_fx3_data(i_fx3_data), .o_fx3_addr(addr5), .o_output_enable(oe5),
        .o_read_enable(re5), .o_data(data5), .o_data_valid(valid5),
        .o_word_count(wc5), .o_in_path_busy(busy5),
        .o_in_path_finished(fin5), .o_short_packet(short5)
    );

    function automatic logic [31:0] data_of(input int c);
        return {8'hD5, c[23:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks one cycle against the bench's expectations, then advances to the next negedge.
    task automatic cycle_check(input logic exp_re, input logic exp_oe, input logic exp_fin);
        logic exp_valid;
        #1;
        exp_valid = re_hist[LAT];
        if (exp_valid) exp_wc++;
        check("read_enable", 32'(o_read_enable), 32'(exp_re));
        check("output_enable", 32'(o_output_enable), 32'(exp_oe));
        check("busy", 32'(o_in_path_busy), 32'(exp_oe));
        check("finished", 32'(o_in_path_finished), 32'(exp_fin));
        check("data_valid", 32'(o_data_valid), 32'(exp_valid));
        check("word_count", 32'(o_word_count), 32'(exp_wc));
        check("fx3_addr", 32'(o_fx3_addr), 32'(exp_addr));
        if (exp_valid) check("data", o_data, data_of(cyc - 1));
        re_hist = {re_hist[14:0], exp_re};
        @(negedge clk);
        cyc++;
        i_fx3_data = data_of(cyc);
    endtask

    // stall_at/abort_at are issued-word counts at which the event starts (-1 = never).
    task automatic run_packet(input int size, input int ch, input int stall_at, input int stall_len,
                              input int abort_at, input logic exp_short, input int exp_words);
        int   issued = 0;
        int   stalled = 0;
        int   last_re = 0;
        int   c0;
        logic f, a, r;
        i_in_path_enable  = 1'b1;
        i_channel         = CW'(ch);
        i_packet_size     = SW'(size);
        i_read_flow_cntrl = 1'b1;
        i_abort           = 1'b0;
        cycle_check(1'b0, 1'b0, 1'b0);
        exp_wc   = 0;
        exp_addr = CW'(ch);
        if (size != 0) begin
            cycle_check(1'b0, 1'b1, 1'b0);
            for (int k = 0; k < 400; k++) begin
                f = !(issued == stall_at && stalled < stall_len);
                a = (issued == abort_at);
                r = f && !a;
                i_read_flow_cntrl = f;
                i_abort           = a;
                if (!f) stalled++;
                c0 = cyc;
                cycle_check(r, 1'b1, 1'b0);
                if (r) begin
                    issued++;
                    last_re = c0;
                end
                if (a || issued == size) break;
            end
            i_read_flow_cntrl = 1'b1;
            i_abort           = 1'b0;
            while (cyc < last_re + LAT + 3) cycle_check(1'b0, 1'b1, 1'b0);
        end
        #1;
        check("short_packet", 32'(o_short_packet), 32'(exp_short));
        check("final_words", 32'(o_word_count), 32'(exp_words));
        cycle_check(1'b0, 1'b0, 1'b1);
        i_in_path_enable = 1'b0;
        cycle_check(1'b0, 1'b0, 1'b1);
        #1;
        check("short_cleared", 32'(o_short_packet), 32'd0);
        cycle_check(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        i_in_path_enable = 1'b0;
        en5 = 1'b0;
        i_channel = '0;
        i_packet_size = '0;
        i_read_flow_cntrl = 1'b0;
        i_abort = 1'b0;
        i_fx3_data = '0;
        re_hist = '0;
        exp_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_re", 32'(o_read_enable), 32'd0);
        check("reset_oe", 32'(o_output_enable), 32'd0);
        check("reset_valid", 32'(o_data_valid), 32'd0);
        check("reset_data", o_data, 32'd0);
        check("reset_wc", 32'(o_word_count), 32'd0);
        check("reset_fin", 32'(o_in_path_finished), 32'd0);
        check("reset_short", 32'(o_short_packet), 32'd0);
        check("reset_addr", 32'(o_fx3_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        i_fx3_data = data_of(0);

        run_packet(8, 2, -1, 0, -1, 1'b0, 8);
        run_packet(16, 1, 6, 5, -1, 1'b0, 16);
        run_packet(10, 3, -1, 0, 4, 1'b1, 4);
        run_packet(0, 1, -1, 0, -1, 1'b0, 0);
        run_packet(6, 2, -1, 0, 5, 1'b1, 5);

        // Reset in the middle of a long packet, then a clean packet.
        i_in_path_enable  = 1'b1;
        i_channel         = 2'd1;
        i_packet_size     = 24'd100;
        i_read_flow_cntrl = 1'b1;
        i_abort           = 1'b0;
        cycle_check(1'b0, 1'b0, 1'b0);
        exp_wc   = 0;
        exp_addr = 2'd1;
        cycle_check(1'b0, 1'b1, 1'b0);
        repeat (10) cycle_check(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cycle_check(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        i_in_path_enable = 1'b0;
        re_hist  = '0;
        exp_wc   = 0;
        exp_addr = '0;
        #1;
        check("post_reset_data", o_data, 32'd0);
        check("post_reset_short", 32'(o_short_packet), 32'd0);
        repeat (6) cycle_check(1'b0, 1'b0, 1'b0);
        run_packet(5, 0, -1, 0, -1, 1'b0, 5);

        // Latency-5 instance, size 3: cycle k counted from the enable cycle.
        i_channel         = 2'd1;
        i_packet_size     = 24'd3;
        i_read_flow_cntrl = 1'b1;
        i_abort           = 1'b0;
        en5               = 1'b1;
        for (int k = 0; k < 15; k++) begin
            #1;
            check("l5_re", 32'(re5), 32'(k >= 2 && k <= 4));
            check("l5_oe", 32'(oe5), 32'(k >= 1 && k <= 11));
            check("l5_busy", 32'(busy5), 32'(k >= 1 && k <= 11));
            check("l5_valid", 32'(valid5), 32'(k >= 8 && k <= 10));
            if (k >= 8 && k <= 10) check("l5_data", data5, data_of(cyc - 1));
            check("l5_finished", 32'(fin5), 32'(k >= 12));
            if (k == 12) begin
                check("l5_words", 32'(wc5), 32'd3);
                check("l5_short", 32'(short5), 32'd0);
                check("l5_addr", 32'(addr5), 32'd1);
            end
            @(negedge clk);
            cyc++;
            i_fx3_data = data_of(cyc);
        end
        en5 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("l5_idle", 32'(fin5), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
